draw_scheduler: RTL and testbench

DRAW_SCHEDULER -- requirements
Module: draw_scheduler

---
 rtl/draw_scheduler.sv | 166 ++++++++++++++++
 tb/tb_draw_scheduler.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/draw_scheduler.sv
// draw_scheduler: arbitrates three square-draw requesters (paddle, ball, brick)
// onto a single VGA pixel-write port. The winner is chosen round-robin, its
// operands are latched at the grant edge, and the square is scanned
// column-major, one pixel per clock. A one-cycle done pulse goes back to the
// owner when the square is finished.
module draw_scheduler (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  req,
  input  logic [29:0] x_in,
  input  logic [29:0] y_in,
  input  logic [29:0] size_in,
  input  logic [8:0]  colour_in,
  output logic [2:0]  done,
  output logic [2:0]  grant,
  output logic        busy,
  output logic        writeEn,
  output logic [9:0]  x_out,
  output logic [9:0]  y_out,
  output logic [2:0]  colour
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  logic [1:0] last;        // index of the most recently granted requester
  logic [9:0] x0;          // latched top-left X of the current square
  logic [9:0] y0;          // latched top-left Y of the current square
  logic [9:0] size_r;      // latched edge length of the current square
  logic [9:0] cx;          // column offset (outer loop)
  logic [9:0] cy;          // row offset (inner loop)

  logic [1:0] win;
  logic [2:0] win_onehot;
  logic [9:0] sel_x;
  logic [9:0] sel_y;
  logic [9:0] sel_size;
  logic [2:0] sel_col;

  // Round-robin pick: search begins at the requester after the last winner.
  // NOTE: every signal driven in always_comb gets a default first so a
  // missing branch can never infer a latch.
  always_comb begin
    win = last;
    case (last)
      2'd0: begin
        if      (req[1]) win = 2'd1;
        else if (req[2]) win = 2'd2;
        else             win = 2'd0;
      end
      2'd1: begin
        if      (req[2]) win = 2'd2;
        else if (req[0]) win = 2'd0;
        else             win = 2'd1;
      end
      default: begin
        if      (req[0]) win = 2'd0;
        else if (req[1]) win = 2'd1;
        else             win = 2'd2;
      end
    endcase
    win_onehot = 3'b001 << win;
  end

  // Operand mux: unpack the winner's fields from the packed input buses.
  always_comb begin
    sel_x    = x_in[9:0];
    sel_y    = y_in[9:0];
    sel_size = size_in[9:0];
    sel_col  = colour_in[2:0];
    case (win)
      2'd1: begin
        sel_x    = x_in[19:10];
        sel_y    = y_in[19:10];
        sel_size = size_in[19:10];
        sel_col  = colour_in[5:3];
      end
      2'd2: begin
        sel_x    = x_in[29:20];
        sel_y    = y_in[29:20];
        sel_size = size_in[29:20];
        sel_col  = colour_in[8:6];
      end
      default: ;
    endcase
  end

  // Scheduler FSM: grant, column-major pixel scan, done handshake.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register updates from pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      last    <= 2'd2;
      x0      <= '0;
      y0      <= '0;
      size_r  <= '0;
      cx      <= '0;
      cy      <= '0;
      done    <= '0;
      grant   <= '0;
      writeEn <= 1'b0;
      x_out   <= '0;
      y_out   <= '0;
      colour  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req != 3'b000) begin
            grant  <= win_onehot;
            last   <= win;
            x0     <= sel_x;
            y0     <= sel_y;
            size_r <= sel_size;
            colour <= sel_col;
            cx     <= '0;
            cy     <= '0;
            if (sel_size == 10'd0) begin
              state <= DONE;
              done  <= win_onehot;
            end else begin
              // First pixel is driven in the very first DRAW cycle.
              state   <= DRAW;
              writeEn <= 1'b1;
              x_out   <= sel_x;
              y_out   <= sel_y;
            end
          end
        end

        DRAW: begin
          if (cy == size_r - 10'd1) begin
            cy <= '0;
            if (cx == size_r - 10'd1) begin
              state   <= DONE;
              writeEn <= 1'b0;
              done    <= grant;
            end else begin
              cx    <= cx + 10'd1;
              x_out <= x0 + cx + 10'd1;
              y_out <= y0;
            end
          end else begin
            cy    <= cy + 10'd1;
            y_out <= y0 + cy + 10'd1;
          end
        end

        DONE: begin
          done  <= '0;
          grant <= '0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_draw_scheduler.sv
// Testbench for draw_scheduler: a scoreboard holds the expected pixel stream
// and done pulses; a negedge monitor pops and compares as the DUT produces
// them, while each scenario task adds its own inline checks.
module tb_draw_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req;
  logic [29:0] x_in;
  logic [29:0] y_in;
  logic [29:0] size_in;
  logic [8:0]  colour_in;
  logic [2:0]  done;
  logic [2:0]  grant;
  logic        busy;
  logic        writeEn;
  logic [9:0]  x_out;
  logic [9:0]  y_out;
  logic [2:0]  colour;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [2:0] c;
    logic [2:0] g;
  } pix_t;

  pix_t       exp_pix[$];
  logic [2:0] exp_done[$];
  pix_t       mon_p;
  logic [2:0] mon_d;
  int         vectors     = 0;
  int         miscompares = 0;
  bit         mon_en      = 1'b0;

  draw_scheduler dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .x_in      (x_in),
    .y_in      (y_in),
    .size_in   (size_in),
    .colour_in (colour_in),
    .done      (done),
    .grant     (grant),
    .busy      (busy),
    .writeEn   (writeEn),
    .x_out     (x_out),
    .y_out     (y_out),
    .colour    (colour)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

  // Monitor: every write and every done pulse must match the scoreboard head.
  always @(negedge clk) begin
    if (mon_en) begin
      if (writeEn === 1'b1) begin
        vectors++;
        if (exp_pix.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_write got x=%0d y=%0d colour=%0d grant=%b", x_out, y_out, colour, grant);
        end else begin
          mon_p = exp_pix.pop_front();
          if ({x_out, y_out, colour, grant} !== mon_p) begin
            miscompares++;
            $display("FAIL pixel got x=%0d y=%0d c=%0d g=%b expected x=%0d y=%0d c=%0d g=%b",
                     x_out, y_out, colour, grant, mon_p.x, mon_p.y, mon_p.c, mon_p.g);
          end
        end
      end
      if (done !== 3'b000) begin
        vectors++;
        if (exp_done.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_done got done=%b grant=%b", done, grant);
        end else begin
          mon_d = exp_done.pop_front();
          if ({done, grant} !== {mon_d, mon_d}) begin
            miscompares++;
            $display("FAIL done_pulse got done=%b grant=%b expected %b", done, grant, mon_d);
          end
        end
      end
    end
  end

  task automatic set_req(input int i, input logic [9:0] x, input logic [9:0] y,
                         input logic [9:0] s, input logic [2:0] c);
    x_in[10*i +: 10]   = x;
    y_in[10*i +: 10]   = y;
    size_in[10*i +: 10] = s;
    colour_in[3*i +: 3] = c;
  endtask

  // Expected column-major scan, optionally truncated to the first 'limit' pixels.
  task automatic push_square(input int i, input logic [9:0] x, input logic [9:0] y,
                             input int s, input logic [2:0] c, input int limit);
    pix_t p;
    int   n = 0;
    for (int ix = 0; ix < s; ix++) begin
      for (int iy = 0; iy < s; iy++) begin
        if (n < limit) begin
          p.x = 10'(int'(x) + ix);
          p.y = 10'(int'(y) + iy);
          p.c = c;
          p.g = 3'(1 << i);
          exp_pix.push_back(p);
        end
        n++;
      end
    end
  endtask

  // Wait for n done pulses; drop the given req bits on the last one.
  task automatic run_until_done(input int n, input int budget, input logic [2:0] drop_mask);
    int seen = 0;
    for (int c = 0; c < budget && seen < n; c++) begin
      @(negedge clk);
      if (done !== 3'b000) begin
        seen++;
        if (seen == n) req = req & ~drop_mask;
      end
    end
    vectors++;
    if (seen < n) begin
      miscompares++;
      $display("FAIL done_timeout got %0d done pulses, expected %0d", seen, n);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req   = 3'b000;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    req       = 3'b000;
    x_in      = '0;
    y_in      = '0;
    size_in   = '0;
    colour_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({writeEn, done, grant, busy} !== 8'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl got we=%b done=%b grant=%b busy=%b expected all 0", writeEn, done, grant, busy);
    end
    vectors++;
    if ({x_out, y_out, colour} !== 23'b0) begin
      miscompares++;
      $display("FAIL reset_pixel got x=%0d y=%0d c=%0d expected 0", x_out, y_out, colour);
    end
    reset  = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_single();
    @(negedge clk);
    set_req(1, 10'd100, 10'd50, 10'd3, 3'd7);
    push_square(1, 10'd100, 10'd50, 3, 3'd7, 9);
    exp_done.push_back(3'b010);
    req = 3'b010;
    @(negedge clk);
    vectors++;
    if ({writeEn, busy, grant, x_out, y_out} !== {1'b1, 1'b1, 3'b010, 10'd100, 10'd50}) begin
      miscompares++;
      $display("FAIL first_write got we=%b busy=%b g=%b x=%0d y=%0d expected 1 1 010 100 50",
               writeEn, busy, grant, x_out, y_out);
    end
    run_until_done(1, 30, 3'b010);
    vectors++;
    if (exp_pix.size() != 0) begin
      miscompares++;
      $display("FAIL single_count got %0d pixels left expected 0", exp_pix.size());
    end
    @(negedge clk);
    vectors++;
    if ({writeEn, busy, grant, done, x_out, y_out} !== {1'b0, 1'b0, 3'b000, 3'b000, 10'd102, 10'd52}) begin
      miscompares++;
      $display("FAIL idle_hold got we=%b busy=%b g=%b d=%b x=%0d y=%0d expected 0 0 000 000 102 52",
               writeEn, busy, grant, done, x_out, y_out);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    set_req(0, 10'd10,  10'd10,  10'd2, 3'd1);
    set_req(1, 10'd200, 10'd20,  10'd2, 3'd2);
    set_req(2, 10'd400, 10'd300, 10'd2, 3'd4);
    push_square(0, 10'd10,  10'd10,  2, 3'd1, 4);  exp_done.push_back(3'b001);
    push_square(1, 10'd200, 10'd20,  2, 3'd2, 4);  exp_done.push_back(3'b010);
    push_square(2, 10'd400, 10'd300, 2, 3'd4, 4);  exp_done.push_back(3'b100);
    push_square(0, 10'd10,  10'd10,  2, 3'd1, 4);  exp_done.push_back(3'b001);
    req = 3'b111;
    run_until_done(4, 100, 3'b111);
    @(negedge clk);
    vectors++;
    if (exp_pix.size() != 0 || exp_done.size() != 0) begin
      miscompares++;
      $display("FAIL rr_drain got %0d pixels %0d dones left expected 0 0", exp_pix.size(), exp_done.size());
    end
  endtask

  task automatic test_zero_size();
    @(negedge clk);
    set_req(2, 10'd5, 10'd5, 10'd0, 3'd3);
    exp_done.push_back(3'b100);
    req = 3'b100;
    @(negedge clk);
    vectors++;
    if ({done, grant, writeEn, busy} !== {3'b100, 3'b100, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL zero_done got d=%b g=%b we=%b busy=%b expected 100 100 0 1", done, grant, writeEn, busy);
    end
    req = 3'b000;
    @(negedge clk);
    vectors++;
    if ({done, busy, writeEn} !== 5'b0) begin
      miscompares++;
      $display("FAIL zero_after got d=%b busy=%b we=%b expected 000 0 0", done, busy, writeEn);
    end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    set_req(0, 10'd1022, 10'd1021, 10'd4, 3'd5);
    push_square(0, 10'd1022, 10'd1021, 4, 3'd5, 16);
    exp_done.push_back(3'b001);
    req = 3'b001;
    run_until_done(1, 40, 3'b001);
  endtask

  task automatic test_mid_change();
    @(negedge clk);
    set_req(1, 10'd300, 10'd400, 10'd3, 3'd2);
    push_square(1, 10'd300, 10'd400, 3, 3'd2, 9);
    exp_done.push_back(3'b010);
    req = 3'b010;
    repeat (4) @(negedge clk);
    set_req(1, 10'd7, 10'd8, 10'd5, 3'd6);
    set_req(0, 10'd1, 10'd2, 10'd9, 3'd1);
    run_until_done(1, 30, 3'b010);
  endtask

  task automatic test_reset_mid_draw();
    @(negedge clk);
    set_req(0, 10'd10, 10'd20, 10'd4, 3'd1);
    push_square(0, 10'd10, 10'd20, 4, 3'd1, 5);
    req = 3'b001;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    req   = 3'b000;
    @(negedge clk);
    vectors++;
    if ({writeEn, done, grant, busy, x_out} !== 18'b0) begin
      miscompares++;
      $display("FAIL abort got we=%b d=%b g=%b busy=%b x=%0d expected all 0", writeEn, done, grant, busy, x_out);
    end
    reset = 1'b0;
    vectors++;
    if (exp_pix.size() != 0) begin
      miscompares++;
      $display("FAIL abort_count got %0d pixels left expected 0", exp_pix.size());
    end
    set_req(0, 10'd33, 10'd44, 10'd1, 3'd6);
    push_square(0, 10'd33, 10'd44, 1, 3'd6, 1);
    exp_done.push_back(3'b001);
    req = 3'b001;
    @(negedge clk);
    vectors++;
    if (grant !== 3'b001) begin
      miscompares++;
      $display("FAIL post_reset_grant got %b expected 001", grant);
    end
    run_until_done(1, 10, 3'b001);
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_zero_size();
    test_wrap();
    test_mid_change();
    test_reset_mid_draw();
    repeat (4) @(negedge clk);
    vectors++;
    if (exp_pix.size() != 0 || exp_done.size() != 0) begin
      miscompares++;
      $display("FAIL final_drain got %0d pixels %0d dones left expected 0 0", exp_pix.size(), exp_done.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
